router_pkt_ctrl: RTL and testbench

Packet-level controller for the 3-port router datapath. It decodes the header beat, selects the destination FIFO and sequences writes into it, including stalls on FIFO-full and waits on a busy destination. It accumulates and checks packet parity. It also runs per-port read-timeout counters that soft-reset abandoned output FIFOs.

---
 rtl/router_pkg.sv | 17 +
 rtl/router_port_timer.sv | 32 +++
 rtl/router_pkt_ctrl.sv | 146 ++++++++++++++
 tb/tb_router_pkt_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and FSM state encoding for the router packet controller.
package router_pkg;
    localparam int DATA_W    = 3;
    localparam int NUM_PORTS = 3;
    localparam int TIMEOUT   = 30;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FIFO_FULL,
        LOAD_AFTER_FULL,
        CHECK_PARITY
    } state_t;
endpackage

// File: rtl/router_port_timer.sv
// Per-port read-timeout counter; pulses soft_reset when a valid FIFO goes unread too long.
module router_port_timer
    import router_pkg::*;
#(
    parameter int LIMIT = TIMEOUT
)(
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);
    localparam int CNT_W = $clog2(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (read_enb || !vld) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == CNT_W'(LIMIT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + CNT_W'(1);
            soft_reset <= 1'b0;
        end
    end
endmodule

// File: rtl/router_pkt_ctrl.sv
// Packet controller: header decode, FIFO write sequencing with stalls, parity check, port timers.
// state           | meaning
// DECODE          | idle, waiting for a valid header
// WAIT_EMPTY      | header latched, destination FIFO still draining
// LOAD_FIRST      | write latched header
// LOAD_DATA       | write payload beats as presented; parity beat ends packet
// FIFO_FULL       | destination full, beat parked in hold
// LOAD_AFTER_FULL | write the parked beat
// CHECK_PARITY    | compare received parity with accumulated parity
module router_pkt_ctrl
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic [DATA_W-1:0]    wr_data,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic                 busy,
    output logic                 err,
    output logic [NUM_PORTS-1:0] soft_reset
);
    state_t              state, state_nxt;
    logic [1:0]          sel;
    logic [DATA_W-1:0]   hold, acc, cmp;
    logic                hold_last;
    logic                wr_en, busy_c;
    logic [1:0]          addr;
    logic                hdr_ok, drop;
    logic [NUM_PORTS-1:0] sel_oh;

    assign addr    = data_in[1:0];
    assign hdr_ok  = pkt_valid && (addr != ADDR_INVALID);
    // A timeout on the selected port abandons the packet from any active state.
    assign drop    = (state != DECODE) && soft_reset[sel];
    assign sel_oh  = NUM_PORTS'(1) << sel;
    assign vld_out = ~fifo_empty;

    assign write_enb = (wr_en && !reset) ? sel_oh : '0;
    assign busy      = busy_c && !reset;

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = data_in;
        case (state)
            DECODE: begin
                if (hdr_ok)
                    state_nxt = fifo_empty[addr] ? LOAD_FIRST : WAIT_EMPTY;
            end
            WAIT_EMPTY: begin
                busy_c = 1'b1;
                if (fifo_empty[sel]) state_nxt = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                busy_c    = 1'b1;
                wr_en     = 1'b1;
                wr_data   = hold;
                state_nxt = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full[sel]) begin
                    state_nxt = FIFO_FULL;
                end else begin
                    wr_en = 1'b1;
                    if (!pkt_valid) state_nxt = CHECK_PARITY;
                end
            end
            FIFO_FULL: begin
                busy_c = 1'b1;
                if (!fifo_full[sel]) state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                busy_c    = 1'b1;
                wr_en     = 1'b1;
                wr_data   = hold;
                state_nxt = hold_last ? LOAD_DATA : CHECK_PARITY;
            end
            CHECK_PARITY: begin
                busy_c    = 1'b1;
                state_nxt = DECODE;
            end
            default: state_nxt = DECODE;
        endcase
        if (drop) state_nxt = DECODE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= DECODE;
            sel       <= '0;
            hold      <= '0;
            hold_last <= 1'b0;
            acc       <= '0;
            cmp       <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (drop) begin
                acc <= '0;
            end else begin
                case (state)
                    DECODE: begin
                        if (hdr_ok) begin
                            sel  <= addr;
                            hold <= data_in;
                            acc  <= data_in;
                            err  <= 1'b0;
                        end
                    end
                    LOAD_DATA: begin
                        if (fifo_full[sel]) begin
                            hold      <= data_in;
                            hold_last <= pkt_valid;
                        end else if (pkt_valid) begin
                            acc <= acc ^ data_in;
                        end else begin
                            cmp <= data_in;
                        end
                    end
                    LOAD_AFTER_FULL: begin
                        if (hold_last) acc <= acc ^ hold;
                        else           cmp <= hold;
                    end
                    CHECK_PARITY: err <= (cmp != acc);
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tmr
        router_port_timer u_tmr (
            .clock      (clock),
            .reset      (reset),
            .vld        (vld_out[i]),
            .read_enb   (read_enb[i]),
            .soft_reset (soft_reset[i])
        );
    end
endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Scoreboard bench for router_pkt_ctrl: packet-level model of expected FIFO writes and parity errors.
module tb_router_pkt_ctrl;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [2:0] data_in, fifo_full, fifo_empty, read_enb;
    logic [2:0] write_enb, wr_data, vld_out, soft_reset;
    logic       busy, err;

    always #5 clock = ~clock;

    router_pkt_ctrl dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .write_enb(write_enb), .wr_data(wr_data), .vld_out(vld_out),
        .busy(busy), .err(err), .soft_reset(soft_reset)
    );

    typedef struct {
        logic [2:0] port_oh;
        logic [2:0] data;
        bit         last;
        bit         perr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_mon;
    logic [2:0] pay_q[$];
    logic [2:0] beat_d[$];
    bit         beat_v[$];
    int         total = 0, bad = 0, wr_cnt = 0, err_cd = 0;
    bit         err_exp = 1'b0, flag_rand = 1'b0, mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference parity: XOR of header and every payload beat.
    function automatic logic [2:0] pkt_parity(input logic [2:0] hdr);
        logic [2:0] x = hdr;
        foreach (pay_q[i]) x ^= pay_q[i];
        return x;
    endfunction

    task automatic make_pkt(input logic [2:0] hdr, input logic [2:0] par);
        exp_t       e;
        logic [2:0] oh = 3'b001 << hdr[1:0];
        beat_d.delete(); beat_v.delete();
        beat_d.push_back(hdr); beat_v.push_back(1'b1);
        foreach (pay_q[i]) begin beat_d.push_back(pay_q[i]); beat_v.push_back(1'b1); end
        beat_d.push_back(par); beat_v.push_back(1'b0);
        foreach (beat_d[i]) begin
            e.port_oh = oh;
            e.data    = beat_d[i];
            e.last    = (i == beat_d.size() - 1);
            e.perr    = (par != pkt_parity(hdr));
            exp_q.push_back(e);
        end
    endtask

    task automatic rand_pkt(input logic [1:0] addr, input int npay, input bit bad_par);
        logic [2:0] hdr, par;
        pay_q.delete();
        repeat (npay) pay_q.push_back(3'($urandom_range(0, 7)));
        hdr = {1'($urandom_range(0, 1)), addr};
        par = pkt_parity(hdr);
        if (bad_par) par ^= 3'($urandom_range(1, 7));
        make_pkt(hdr, par);
    endtask

    // Source side: a beat is consumed at the edge where busy was low.
    task automatic drive_from(input int start, output int cyc);
        int idx = start;
        bit take;
        cyc = 0;
        while (idx < beat_d.size()) begin
            data_in   = beat_d[idx];
            pkt_valid = beat_v[idx];
            if (flag_rand) begin
                fifo_empty = 3'($urandom_range(0, 7));
                fifo_full  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 3) == 0)};
            end
            take = !busy;
            @(posedge clock); #1;
            if (take) idx++;
            cyc++;
            if (cyc > 300) begin
                total++; bad++;
                $display("FAIL drive_timeout: got beat %0d expected %0d", idx, beat_d.size());
                break;
            end
        end
        pkt_valid = 1'b0;
        data_in   = 3'($urandom_range(0, 7));
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (err_cd > 0) begin
                err_cd = err_cd - 1;
                if (err_cd == 1) chk("busy_check_parity", 32'(busy), 32'(1));
                else if (err_cd == 0) chk("err", 32'(err), 32'(err_exp));
            end
            if (write_enb != 3'b000) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got we=%b data=%b expected none", write_enb, wr_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("wr_port", 32'(write_enb), 32'(e_mon.port_oh));
                    chk("wr_data", 32'(wr_data), 32'(e_mon.data));
                    wr_cnt++;
                    if (e_mon.last) begin
                        err_cd  = 2;
                        err_exp = e_mon.perr;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, base, g;
        reset = 1'b1; pkt_valid = 1'b0; data_in = 3'b000;
        fifo_full = 3'b000; fifo_empty = 3'b000; read_enb = 3'b000;

        // Timers must stay idle through a long reset even with unread data.
        for (int k = 1; k <= 35; k++) begin
            @(posedge clock); #1;
            chk("rst_soft_reset", 32'(soft_reset), 32'(0));
        end
        chk("rst_write_enb", 32'(write_enb), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        fifo_empty = 3'b111; read_enb = 3'b111; reset = 1'b0; mon_en = 1'b1;
        @(posedge clock); #1;

        // Port 1 packet, good parity: header then one beat per cycle after the busy slot.
        pay_q = '{3'b101, 3'b011};
        make_pkt(3'b001, 3'b111);
        drive_from(0, cyc);
        chk("p1_cycles", 32'(cyc), 32'(5));
        repeat (3) begin @(posedge clock); #1; end

        // Same packet with wrong parity; err must persist until a valid header.
        make_pkt(3'b001, 3'b000);
        drive_from(0, cyc);
        repeat (4) begin @(posedge clock); #1; end
        chk("err_held", 32'(err), 32'(1));
        for (int k = 0; k < 4; k++) begin
            data_in = 3'b011; pkt_valid = 1'b1;
            @(posedge clock); #1;
            chk("bad_addr_busy", 32'(busy), 32'(0));
            chk("bad_addr_we", 32'(write_enb), 32'(0));
            chk("bad_addr_err", 32'(err), 32'(1));
        end
        pkt_valid = 1'b0;
        @(posedge clock); #1;

        // Timeout while waiting on port 0 drops the packet.
        fifo_empty = 3'b110; read_enb = 3'b110; data_in = 3'b000; pkt_valid = 1'b1;
        @(posedge clock); #1;
        pkt_valid = 1'b0;
        for (int k = 2; k <= 31; k++) begin
            @(posedge clock); #1;
            if (k == 30) begin
                chk("drop_busy_pre", 32'(busy), 32'(1));
                chk("drop_pulse", 32'(soft_reset), 32'(3'b001));
            end
        end
        chk("drop_busy_post", 32'(busy), 32'(0));
        chk("drop_pulse_end", 32'(soft_reset), 32'(0));
        chk("err_after_drop", 32'(err), 32'(0));
        fifo_empty = 3'b111; read_enb = 3'b111;
        @(posedge clock); #1;
        rand_pkt(2'd0, 3, 1'b0);
        drive_from(0, cyc);
        repeat (3) begin @(posedge clock); #1; end

        // Destination busy: header waits, then is written the cycle after empty rises.
        pay_q = '{3'b110};
        make_pkt(3'b010, pkt_parity(3'b010));
        fifo_empty = 3'b011; data_in = beat_d[0]; pkt_valid = 1'b1;
        @(posedge clock); #1;
        data_in = beat_d[1];
        repeat (5) begin
            chk("wait_busy", 32'(busy), 32'(1));
            chk("wait_we", 32'(write_enb), 32'(0));
            @(posedge clock); #1;
        end
        fifo_empty = 3'b111;
        @(posedge clock); #1;
        chk("wait_hdr_we", 32'(write_enb), 32'(3'b100));
        chk("wait_hdr_data", 32'(wr_data), 32'(3'b010));
        drive_from(1, cyc);
        repeat (3) begin @(posedge clock); #1; end

        // FIFO full on the second payload beat of a port 0 packet.
        pay_q = '{3'b111, 3'b100, 3'b001};
        make_pkt(3'b000, pkt_parity(3'b000));
        base = wr_cnt;
        fork
            drive_from(0, cyc);
            begin
                g = 0;
                while (wr_cnt < base + 2 && g < 50) begin @(posedge clock); #2; g++; end
                chk("full_sync", 32'(wr_cnt), 32'(base + 2));
                fifo_full = 3'b001;
                repeat (3) begin
                    @(posedge clock); #2;
                    chk("full_busy", 32'(busy), 32'(1));
                    chk("full_we", 32'(write_enb), 32'(0));
                end
                fifo_full = 3'b000;
            end
        join
        repeat (3) begin @(posedge clock); #1; end

        // Ports 0 and 2 time out together after 30 unread cycles.
        fifo_empty = 3'b010; read_enb = 3'b010;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clock); #1;
            chk("tmo_pulse", 32'(soft_reset), (k == 30) ? 32'(3'b101) : 32'(0));
        end
        chk("vld_out", 32'(vld_out), 32'(3'b101));
        fifo_empty = 3'b111; read_enb = 3'b111;
        @(posedge clock); #1;

        // A read at cycle 29 restarts the count: no pulse.
        fifo_empty = 3'b110;
        for (int k = 1; k <= 36; k++) begin
            read_enb = (k == 29) ? 3'b111 : 3'b110;
            @(posedge clock); #1;
            chk("tmo_no_pulse", 32'(soft_reset), 32'(0));
        end
        fifo_empty = 3'b111; read_enb = 3'b111;
        @(posedge clock); #1;

        // Random packets with random empty/full back-pressure.
        flag_rand = 1'b1;
        repeat (40) rand_pkt(2'($urandom_range(0, 2)), $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
        exp_q.delete();
        for (int p = 0; p < 40; p++) begin
            rand_pkt(2'($urandom_range(0, 2)), $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
            drive_from(0, cyc);
        end
        flag_rand = 1'b0; fifo_full = 3'b000; fifo_empty = 3'b111;
        repeat (6) begin @(posedge clock); #1; end
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        chk("err_cd_done", 32'(err_cd), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
